// File: rtl/alu_arbiter_if.sv
// Bus bundle between two requesters, the shared ALU, the response consumer and alu_arbiter.
// The slave modport is the arbiter's view; the master modport is the surrounding system's view.
interface alu_arbiter_if #(
   parameter int unsigned DATA_W = 32
);

   // Requester 0
   logic              req0_valid;
   logic              req0_ready;
   logic [3:0]        req0_control;
   logic [DATA_W-1:0] req0_op1;
   logic [DATA_W-1:0] req0_op2;
   logic [4:0]        req0_shamt;

   // Requester 1
   logic              req1_valid;
   logic              req1_ready;
   logic [3:0]        req1_control;
   logic [DATA_W-1:0] req1_op1;
   logic [DATA_W-1:0] req1_op2;
   logic [4:0]        req1_shamt;

   // Shared ALU
   logic [3:0]        ALU_control;
   logic [DATA_W-1:0] ALU_operand_1;
   logic [DATA_W-1:0] ALU_operand_2;
   logic [4:0]        ALU_shamt;
   logic [DATA_W-1:0] ALU_result;
   logic [7:0]        ALU_status;

   // Response channel
   logic              rsp_valid;
   logic              rsp_ready;
   logic              rsp_id;
   logic [DATA_W-1:0] rsp_result;
   logic [7:0]        rsp_status;

   logic              busy;

   modport slave (
      input  req0_valid, req0_control, req0_op1, req0_op2, req0_shamt,
      output req0_ready,
      input  req1_valid, req1_control, req1_op1, req1_op2, req1_shamt,
      output req1_ready,
      output ALU_control, ALU_operand_1, ALU_operand_2, ALU_shamt,
      input  ALU_result, ALU_status,
      output rsp_valid, rsp_id, rsp_result, rsp_status,
      input  rsp_ready,
      output busy
   );

   modport master (
      output req0_valid, req0_control, req0_op1, req0_op2, req0_shamt,
      input  req0_ready,
      output req1_valid, req1_control, req1_op1, req1_op2, req1_shamt,
      input  req1_ready,
      input  ALU_control, ALU_operand_1, ALU_operand_2, ALU_shamt,
      output ALU_result, ALU_status,
      input  rsp_valid, rsp_id, rsp_result, rsp_status,
      output rsp_ready,
      input  busy
   );

endinterface

// File: rtl/alu_arbiter.sv
// Two-requester arbiter in front of one shared single-cycle ALU.
// Flow: IDLE (grant/accept) -> EXEC (capture ALU outputs) -> RESP (hold until consumed).
// Optional macro ALU_ARB_FIXED_PRIO_EN: requester 0 always wins contention; otherwise
// contention is resolved round-robin against the last granted requester.
module alu_arbiter #(
   parameter int unsigned DATA_W = 32
) (
   input logic          clk,
   input logic          reset,
   alu_arbiter_if.slave bus_io
);

   typedef enum logic [1:0] {StIdle, StExec, StResp} state_e;

   state_e            state_q;
   logic              last_grant_q;
   logic              id_q;
   logic              busy_q;
   logic              rsp_valid_q;
   logic [3:0]        ctl_q;
   logic [DATA_W-1:0] op1_q;
   logic [DATA_W-1:0] op2_q;
   logic [4:0]        shamt_q;
   logic [DATA_W-1:0] res_q;
   logic [7:0]        stat_q;

   logic gnt_valid;
   logic gnt_id;
   logic accept;

`ifdef ALU_ARB_FIXED_PRIO_EN
   // Last grant is still tracked but has no influence on the grant in this build.
   logic unused_last_grant;
   assign unused_last_grant = last_grant_q;
`endif

   // Combinational grant from the valids (and last grant in round-robin mode)
   always_comb begin
      gnt_valid = bus_io.req0_valid | bus_io.req1_valid;
`ifdef ALU_ARB_FIXED_PRIO_EN
      gnt_id    = bus_io.req1_valid & ~bus_io.req0_valid;
`else
      if (bus_io.req0_valid && bus_io.req1_valid) begin
         gnt_id = ~last_grant_q;
      end else begin
         gnt_id = bus_io.req1_valid;
      end
`endif
      // Ready is only offered in IDLE and never while reset is asserted.
      accept            = (state_q == StIdle) & gnt_valid & ~reset;
      bus_io.req0_ready = accept & ~gnt_id;
      bus_io.req1_ready = accept & gnt_id;
   end

   // FSM plus registered operation, response and status outputs
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= StIdle;
         last_grant_q <= 1'b1;
         id_q         <= 1'b0;
         busy_q       <= 1'b0;
         rsp_valid_q  <= 1'b0;
         ctl_q        <= '0;
         op1_q        <= '0;
         op2_q        <= '0;
         shamt_q      <= '0;
         res_q        <= '0;
         stat_q       <= '0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (accept) begin
                  if (gnt_id) begin
                     ctl_q   <= bus_io.req1_control;
                     op1_q   <= bus_io.req1_op1;
                     op2_q   <= bus_io.req1_op2;
                     shamt_q <= bus_io.req1_shamt;
                  end else begin
                     ctl_q   <= bus_io.req0_control;
                     op1_q   <= bus_io.req0_op1;
                     op2_q   <= bus_io.req0_op2;
                     shamt_q <= bus_io.req0_shamt;
                  end
                  id_q         <= gnt_id;
                  last_grant_q <= gnt_id;
                  busy_q       <= 1'b1;
                  state_q      <= StExec;
               end
            end
            StExec: begin
               // ALU is single-cycle: its outputs for the registered op are valid now.
               res_q       <= bus_io.ALU_result;
               stat_q      <= bus_io.ALU_status;
               rsp_valid_q <= 1'b1;
               state_q     <= StResp;
            end
            StResp: begin
               if (bus_io.rsp_ready) begin
                  rsp_valid_q <= 1'b0;
                  busy_q      <= 1'b0;
                  state_q     <= StIdle;
               end
            end
            default: begin
               state_q <= StIdle;
            end
         endcase
      end
   end

   // ALU drive comes only from the registered operation
   always_comb begin
      bus_io.ALU_control   = ctl_q;
      bus_io.ALU_operand_1 = op1_q;
      bus_io.ALU_operand_2 = op2_q;
      bus_io.ALU_shamt     = shamt_q;
   end

   // Response and status outputs; rsp_valid is masked during reset
   always_comb begin
      bus_io.rsp_valid  = rsp_valid_q & ~reset;
      bus_io.rsp_id     = id_q;
      bus_io.rsp_result = res_q;
      bus_io.rsp_status = stat_q;
      bus_io.busy       = busy_q;
   end

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter with a behavioural single-cycle ALU model.
module tb_alu_arbiter;

   localparam logic [3:0] OpAnd = 4'd0;
   localparam logic [3:0] OpOr  = 4'd1;
   localparam logic [3:0] OpAdd = 4'd2;
   localparam logic [3:0] OpSll = 4'd3;
   localparam logic [3:0] OpSrl = 4'd4;
   localparam logic [3:0] OpSub = 4'd6;
   localparam logic [3:0] OpSlt = 4'd7;
   localparam logic [3:0] OpMul = 4'd8;
   localparam logic [3:0] OpDiv = 4'd9;
   localparam logic [3:0] OpNor = 4'd12;

   typedef struct {
      bit          id;
      logic [3:0]  ctl;
      logic [31:0] a;
      logic [31:0] b;
      logic [4:0]  sh;
      logic [31:0] res;
      logic [7:0]  st;
   } vec_t;

   logic clk;
   logic reset;
   int   checks;
   int   failures;

   alu_arbiter_if #(.DATA_W(32)) bus ();

   alu_arbiter #(.DATA_W(32)) dut (
      .clk    (clk),
      .reset  (reset),
      .bus_io (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural ALU: status = {zero, ovf, carry, neg, inv_addr, div_zero, 2'b00}
   logic [32:0] alu_wide;
   logic [31:0] alu_r;
   logic        alu_c;
   logic        alu_v;
   logic        alu_dz;
   always_comb begin
      alu_wide = '0;
      alu_r    = '0;
      alu_c    = 1'b0;
      alu_v    = 1'b0;
      alu_dz   = 1'b0;
      case (bus.ALU_control)
         OpAnd: alu_r = bus.ALU_operand_1 & bus.ALU_operand_2;
         OpOr:  alu_r = bus.ALU_operand_1 | bus.ALU_operand_2;
         OpNor: alu_r = ~(bus.ALU_operand_1 | bus.ALU_operand_2);
         OpAdd: begin
            alu_wide = {1'b0, bus.ALU_operand_1} + {1'b0, bus.ALU_operand_2};
            alu_r    = alu_wide[31:0];
            alu_c    = alu_wide[32];
            alu_v    = (bus.ALU_operand_1[31] == bus.ALU_operand_2[31]) &&
                       (alu_r[31] != bus.ALU_operand_1[31]);
         end
         OpSub: begin
            alu_r = bus.ALU_operand_1 - bus.ALU_operand_2;
            alu_c = bus.ALU_operand_1 < bus.ALU_operand_2;
            alu_v = (bus.ALU_operand_1[31] != bus.ALU_operand_2[31]) &&
                    (alu_r[31] != bus.ALU_operand_1[31]);
         end
         OpSlt: alu_r = {31'd0, $signed(bus.ALU_operand_1) < $signed(bus.ALU_operand_2)};
         OpSll: alu_r = bus.ALU_operand_1 << bus.ALU_shamt;
         OpSrl: alu_r = bus.ALU_operand_1 >> bus.ALU_shamt;
         OpMul: alu_r = bus.ALU_operand_1 * bus.ALU_operand_2;
         OpDiv: begin
            if (bus.ALU_operand_2 == 32'd0) alu_dz = 1'b1;
            else alu_r = bus.ALU_operand_1 / bus.ALU_operand_2;
         end
         default: alu_r = '0;
      endcase
      bus.ALU_result = alu_r;
      bus.ALU_status = {alu_r == 32'd0, alu_v, alu_c, alu_r[31], 1'b0, alu_dz, 2'b00};
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic drive_req(input bit id, input logic v, input logic [3:0] ctl,
                            input logic [31:0] a, input logic [31:0] b, input logic [4:0] sh);
      if (id == 1'b0) begin
         bus.req0_valid = v; bus.req0_control = ctl;
         bus.req0_op1 = a; bus.req0_op2 = b; bus.req0_shamt = sh;
      end else begin
         bus.req1_valid = v; bus.req1_control = ctl;
         bus.req1_op1 = a; bus.req1_op2 = b; bus.req1_shamt = sh;
      end
   endtask

   // One isolated transaction with fixed latency: accept, EXEC, RESP, handshake.
   task automatic run_vec(input vec_t v, input string tag);
      @(negedge clk);
      drive_req(v.id, 1'b1, v.ctl, v.a, v.b, v.sh);
      #1;
      check({tag, "_ready"}, 32'(v.id ? bus.req1_ready : bus.req0_ready), 32'd1);
      @(posedge clk);
      @(negedge clk);
      drive_req(v.id, 1'b0, 4'd0, 32'd0, 32'd0, 5'd0);
      check({tag, "_exec_busy"}, 32'(bus.busy), 32'd1);
      check({tag, "_exec_no_rsp"}, 32'(bus.rsp_valid), 32'd0);
      check({tag, "_alu_op1"}, bus.ALU_operand_1, v.a);
      @(negedge clk);
      check({tag, "_rsp_valid"}, 32'(bus.rsp_valid), 32'd1);
      check({tag, "_rsp_id"}, 32'(bus.rsp_id), 32'(v.id));
      check({tag, "_rsp_result"}, bus.rsp_result, v.res);
      check({tag, "_rsp_status"}, 32'(bus.rsp_status), 32'(v.st));
      bus.rsp_ready = 1'b1;
      @(negedge clk);
      bus.rsp_ready = 1'b0;
      check({tag, "_idle_busy"}, 32'(bus.busy), 32'd0);
      check({tag, "_idle_rsp"}, 32'(bus.rsp_valid), 32'd0);
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
   endtask

   vec_t vecs[9];
   vec_t v_sub34;
   int   exp_gr[4];
   int   ngr;
   int   last_c;

   initial begin
      vecs[0] = '{0, OpAdd, 32'd5,          32'd7,          5'd0, 32'd12,         8'h00};
      vecs[1] = '{1, OpDiv, 32'd10,         32'd0,          5'd0, 32'd0,          8'h84};
      vecs[2] = '{0, OpSub, 32'd0,          32'd1,          5'd0, 32'hFFFF_FFFF,  8'h30};
      vecs[3] = '{1, OpAnd, 32'hF0F0_F0F0,  32'hFF00_FF00,  5'd0, 32'hF000_F000,  8'h10};
      vecs[4] = '{0, OpOr,  32'd0,          32'd0,          5'd0, 32'd0,          8'h80};
      vecs[5] = '{1, OpAdd, 32'h7FFF_FFFF,  32'd1,          5'd0, 32'h8000_0000,  8'h50};
      vecs[6] = '{0, OpSll, 32'd1,          32'd0,          5'd4, 32'd16,         8'h00};
      vecs[7] = '{1, OpSub, 32'd3,          32'd4,          5'd0, 32'hFFFF_FFFF,  8'h30};
      vecs[8] = '{0, OpAdd, 32'hFFFF_FFFF,  32'd1,          5'd0, 32'd0,          8'hA0};
      v_sub34 = '{0, OpSub, 32'd3,          32'd4,          5'd0, 32'hFFFF_FFFF,  8'h30};
`ifdef ALU_ARB_FIXED_PRIO_EN
      exp_gr = '{0, 0, 0, 0};
`else
      exp_gr = '{0, 1, 0, 1};
`endif
      checks   = 0;
      failures = 0;
      reset    = 1'b1;
      bus.rsp_ready = 1'b0;
      drive_req(1'b0, 1'b1, OpAdd, 32'd1, 32'd1, 5'd0);
      drive_req(1'b1, 1'b1, OpAdd, 32'd2, 32'd2, 5'd0);

      // Reset state, with both requesters valid while reset is held
      @(negedge clk);
      @(negedge clk);
      check("rst_ready0", 32'(bus.req0_ready), 32'd0);
      check("rst_ready1", 32'(bus.req1_ready), 32'd0);
      check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
      check("rst_busy", 32'(bus.busy), 32'd0);
      check("rst_rsp_result", bus.rsp_result, 32'd0);
      check("rst_rsp_status", 32'(bus.rsp_status), 32'd0);
      check("rst_alu_op1", bus.ALU_operand_1, 32'd0);
      drive_req(1'b0, 1'b0, 4'd0, 32'd0, 32'd0, 5'd0);
      drive_req(1'b1, 1'b0, 4'd0, 32'd0, 32'd0, 5'd0);
      reset = 1'b0;

      // Table-driven single-requester transactions
      for (int i = 0; i < 9; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

      // Contention after reset: grant order and back-to-back issue interval
      do_reset();
      @(negedge clk);
      drive_req(1'b0, 1'b1, OpAdd, 32'd1, 32'd1, 5'd0);
      drive_req(1'b1, 1'b1, OpAdd, 32'd2, 32'd2, 5'd0);
      bus.rsp_ready = 1'b1;
      ngr    = 0;
      last_c = 0;
      for (int c = 0; c < 30 && ngr < 4; c++) begin
         #1;
         if (bus.req0_ready || bus.req1_ready) begin
            check($sformatf("rr_one_hot%0d", ngr), 32'(bus.req0_ready & bus.req1_ready), 32'd0);
            check($sformatf("rr_grant%0d", ngr), 32'(bus.req1_ready), 32'(exp_gr[ngr]));
            if (ngr > 0) check($sformatf("rr_interval%0d", ngr), 32'(c - last_c), 32'd3);
            last_c = c;
            ngr++;
         end
         @(negedge clk);
      end
      check("rr_grant_count", 32'(ngr), 32'd4);
      drive_req(1'b0, 1'b0, 4'd0, 32'd0, 32'd0, 5'd0);
      drive_req(1'b1, 1'b0, 4'd0, 32'd0, 32'd0, 5'd0);
      repeat (4) @(negedge clk);
      bus.rsp_ready = 1'b0;
      check("rr_drained_busy", 32'(bus.busy), 32'd0);

      // Response back-pressure with req0 kept valid
      @(negedge clk);
      drive_req(1'b0, 1'b1, OpAdd, 32'd5, 32'd7, 5'd0);
      @(posedge clk);
      @(negedge clk);
      drive_req(1'b0, 1'b1, OpAdd, 32'd1, 32'd2, 5'd0);
      check("bp_exec_ready0", 32'(bus.req0_ready), 32'd0);
      @(negedge clk);
      for (int k = 0; k < 5; k++) begin
         check($sformatf("bp_valid%0d", k), 32'(bus.rsp_valid), 32'd1);
         check($sformatf("bp_result%0d", k), bus.rsp_result, 32'd12);
         check($sformatf("bp_id%0d", k), 32'(bus.rsp_id), 32'd0);
         check($sformatf("bp_ready0_%0d", k), 32'(bus.req0_ready), 32'd0);
         check($sformatf("bp_alu_op1_%0d", k), bus.ALU_operand_1, 32'd5);
         @(negedge clk);
      end
      bus.rsp_ready = 1'b1;
      #1;
      check("bp_hs_ready0", 32'(bus.req0_ready), 32'd0);
      @(negedge clk);
      bus.rsp_ready = 1'b0;
      check("bp_after_busy", 32'(bus.busy), 32'd0);
      check("bp_after_ready0", 32'(bus.req0_ready), 32'd1);
      @(negedge clk);
      drive_req(1'b0, 1'b0, 4'd0, 32'd0, 32'd0, 5'd0);
      check("bp_next_busy", 32'(bus.busy), 32'd1);
      check("bp_next_op1", bus.ALU_operand_1, 32'd1);
      @(negedge clk);
      check("bp_next_valid", 32'(bus.rsp_valid), 32'd1);
      check("bp_next_result", bus.rsp_result, 32'd3);
      bus.rsp_ready = 1'b1;
      @(negedge clk);
      bus.rsp_ready = 1'b0;

      // Reset during EXEC discards the operation
      @(negedge clk);
      drive_req(1'b0, 1'b1, OpSub, 32'd3, 32'd4, 5'd0);
      @(posedge clk);
      @(negedge clk);
      drive_req(1'b0, 1'b0, 4'd0, 32'd0, 32'd0, 5'd0);
      drive_req(1'b1, 1'b1, OpAdd, 32'd9, 32'd9, 5'd0);
      reset = 1'b1;
      #1;
      check("exrst_ready1", 32'(bus.req1_ready), 32'd0);
      check("exrst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
      @(negedge clk);
      check("exrst_busy", 32'(bus.busy), 32'd0);
      check("exrst_rsp_result", bus.rsp_result, 32'd0);
      reset = 1'b0;
      drive_req(1'b1, 1'b0, 4'd0, 32'd0, 32'd0, 5'd0);
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         check($sformatf("exrst_quiet%0d", k), 32'(bus.rsp_valid), 32'd0);
      end
      run_vec(v_sub34, "exrst_retry");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   // Absolute time bound in case any sequence stalls
   initial begin
      #200000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1, "timeout");
   end

endmodule
